// File: rtl/sweep_profile_bank.sv
// DDS sweep profile store: indexed slot writes plus a step-driven playback sequencer
// that replays slots 0..last_idx, optionally looping, with write-to-load bypass.

module sweep_profile_slot #(
  parameter int WORD_W = 184
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);
  logic [WORD_W-1:0] word_q, word_d;

  // Clear first, then write, so a same-cycle write survives the clear.
  always_comb begin
    word_d = word_q;
    if (clr) word_d = '0;
    if (we)  word_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign dout = word_q;
endmodule

module sweep_profile_bank #(
  parameter int WORD_W = 184,
  parameter int DEPTH  = 12,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              loop_en,
  output logic [WORD_W-1:0] play_word,
  output logic [IDX_W-1:0]  play_idx,
  output logic              play_valid,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  last_idx,
  output logic              any_valid
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] play_word_q, play_word_d;
  logic [IDX_W-1:0]  play_idx_q, play_idx_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic              any_valid_q, any_valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic              done_q, done_d;

  logic                         wr_ok, do_clear, load;
  logic [IDX_W-1:0]             load_idx, last_base;
  logic [WORD_W-1:0]            rd_word;
  logic [DEPTH-1:0][WORD_W-1:0] slot_rd;

  assign wr_ok    = wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(DEPTH));
  assign do_clear = clear && (state_q == IDLE);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    sweep_profile_slot #(.WORD_W(WORD_W)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (do_clear),
      .we   (wr_ok && (wr_idx == IDX_W'(g))),
      .din  (wr_data),
      .dout (slot_rd[g])
    );
  end

  // Read mux for the slot being loaded; load_idx never exceeds last_idx < DEPTH.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (load_idx == IDX_W'(i)) rd_word = slot_rd[i];
  end

  always_comb begin
    state_d     = state_q;
    play_idx_d  = play_idx_q;
    play_word_d = play_word_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_idx    = '0;
    wr_ack_d    = wr_ok;
    wr_err_d    = wr_en && !wr_ok;

    last_base   = do_clear ? '0 : last_idx_q;
    any_valid_d = do_clear ? 1'b0 : any_valid_q;
    last_idx_d  = last_base;
    if (wr_ok) begin
      any_valid_d = 1'b1;
      last_idx_d  = (wr_idx > last_base) ? wr_idx : last_base;
    end

    // Sequencer decisions use the bound registered before this edge.
    case (state_q)
      IDLE: begin
        if (start && any_valid_q && !clear) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (step) begin
          if (play_idx_q < last_idx_q) begin
            load     = 1'b1;
            load_idx = play_idx_q + IDX_W'(1);
          end else if (loop_en) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      play_idx_d  = load_idx;
      play_word_d = (wr_ok && (wr_idx == load_idx)) ? wr_data : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      play_word_q <= '0;
      play_idx_q  <= '0;
      last_idx_q  <= '0;
      any_valid_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      play_word_q <= play_word_d;
      play_idx_q  <= play_idx_d;
      last_idx_q  <= last_idx_d;
      any_valid_q <= any_valid_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      done_q      <= done_d;
    end
  end

  assign play_word  = play_word_q;
  assign play_idx   = play_idx_q;
  assign play_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign last_idx   = last_idx_q;
  assign any_valid  = any_valid_q;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
endmodule

// File: tb/tb_sweep_profile_bank.sv
// Bench for sweep_profile_bank: directed vector table, reset-mid-run sequence,
// then randomized traffic checked against an array-based reference model.

module tb_sweep_profile_bank;
  localparam int WORD_W = 184;
  localparam int DEPTH  = 12;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [IDX_W-1:0]  wr_idx = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              clear = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0, loop_en = 1'b0;
  logic              wr_ack, wr_err, play_valid, busy, done, any_valid;
  logic [WORD_W-1:0] play_word;
  logic [IDX_W-1:0]  play_idx, last_idx;

  int n_cmp = 0;
  int n_fail = 0;

  sweep_profile_bank #(.WORD_W(WORD_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .clear(clear), .start(start), .stop(stop),
    .step(step), .loop_en(loop_en), .play_word(play_word), .play_idx(play_idx),
    .play_valid(play_valid), .busy(busy), .done(done), .last_idx(last_idx),
    .any_valid(any_valid)
  );

  always #5 clk = ~clk;

  // Reference model: plain slot array plus a playing flag and cursor.
  logic [WORD_W-1:0] m_mem [DEPTH];
  int   m_last, m_idx;
  logic m_any, m_run, m_done, m_ack, m_err;
  logic [WORD_W-1:0] m_word;

  function automatic logic [WORD_W-1:0] mkword(input logic [7:0] tag);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W / 8; i++) w[i*8 +: 8] = tag;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] rnd_word();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_last = 0; m_idx = 0; m_any = 0; m_run = 0;
    m_done = 0; m_ack = 0; m_err = 0; m_word = '0;
  endtask

  task automatic model_edge();
    int   old_last = m_last;
    logic old_any  = m_any;
    logic ok       = wr_en && (int'(wr_idx) < DEPTH);
    m_ack = ok; m_err = wr_en && !ok; m_done = 0;
    if (clear && !m_run) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_last = 0; m_any = 0;
    end
    if (ok) begin
      m_mem[int'(wr_idx)] = wr_data;
      m_any = 1;
      if (int'(wr_idx) > m_last) m_last = int'(wr_idx);
    end
    // Loads read the array after this edge's write, so a same-edge write wins.
    if (!m_run) begin
      if (start && old_any && !clear) begin
        m_run = 1; m_idx = 0; m_word = m_mem[0];
      end
    end else if (stop) begin
      m_run = 0;
    end else if (step) begin
      if (m_idx < old_last) begin
        m_idx++; m_word = m_mem[m_idx];
      end else if (loop_en) begin
        m_idx = 0; m_word = m_mem[0];
      end else begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eidx, input logic [WORD_W-1:0] eword,
                         input logic evalid, input logic edone, input logic eack,
                         input logic eerr, input int elast, input logic eany);
    chk({tag, ".play_idx"},   WORD_W'(play_idx),   WORD_W'(eidx));
    chk({tag, ".play_word"},  play_word,           eword);
    chk({tag, ".play_valid"}, WORD_W'(play_valid), WORD_W'(evalid));
    chk({tag, ".busy"},       WORD_W'(busy),       WORD_W'(evalid));
    chk({tag, ".done"},       WORD_W'(done),       WORD_W'(edone));
    chk({tag, ".wr_ack"},     WORD_W'(wr_ack),     WORD_W'(eack));
    chk({tag, ".wr_err"},     WORD_W'(wr_err),     WORD_W'(eerr));
    chk({tag, ".last_idx"},   WORD_W'(last_idx),   WORD_W'(elast));
    chk({tag, ".any_valid"},  WORD_W'(any_valid),  WORD_W'(eany));
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_idx, m_word, m_run, m_done, m_ack, m_err, m_last, m_any);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_idx = '0; wr_data = '0;
    clear = 0; start = 0; stop = 0; step = 0; loop_en = 0;
  endtask

  typedef struct {
    logic       we;
    int         widx;
    logic [7:0] wtag;
    logic       clr, sta, stp, stv, lp;
    int         eidx;
    logic [7:0] etag;
    logic       evalid, edone, eack, eerr;
    int         elast;
    logic       eany;
  } vec_t;

  vec_t tbl[$];

  initial begin
    model_reset();
    // we idx tag clr sta stp stv lp | idx tag valid done ack err last any
    tbl.push_back('{1, 0, 8'hA1, 0,0,0,0,0,  0, 8'h00, 0,0,1,0, 0,1}); // write A
    tbl.push_back('{1, 1, 8'hB2, 0,0,0,0,0,  0, 8'h00, 0,0,1,0, 1,1}); // write B
    tbl.push_back('{1, 2, 8'hC3, 0,0,0,0,0,  0, 8'h00, 0,0,1,0, 2,1}); // write C
    tbl.push_back('{0, 0, 8'h00, 0,1,0,0,0,  0, 8'hA1, 1,0,0,0, 2,1}); // start
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  1, 8'hB2, 1,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  2, 8'hC3, 1,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  2, 8'hC3, 0,1,0,0, 2,1}); // finish, done
    tbl.push_back('{0, 0, 8'h00, 0,0,0,0,0,  2, 8'hC3, 0,0,0,0, 2,1});
    tbl.push_back('{1,12, 8'hDD, 0,0,0,0,0,  2, 8'hC3, 0,0,0,1, 2,1}); // out of range
    tbl.push_back('{0, 0, 8'h00, 0,0,0,0,0,  2, 8'hC3, 0,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,1,0,0,1,  0, 8'hA1, 1,0,0,0, 2,1}); // looping run
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,1,  1, 8'hB2, 1,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,1,  2, 8'hC3, 1,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,1,  0, 8'hA1, 1,0,0,0, 2,1}); // wrap
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,1,  1, 8'hB2, 1,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,1,  2, 8'hC3, 1,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,1,1,1,  2, 8'hC3, 0,0,0,0, 2,1}); // stop beats step
    tbl.push_back('{0, 0, 8'h00, 0,1,0,0,0,  0, 8'hA1, 1,0,0,0, 2,1});
    tbl.push_back('{1, 1, 8'hE5, 0,0,0,1,0,  1, 8'hE5, 1,0,1,0, 2,1}); // step+write bypass
    tbl.push_back('{0, 0, 8'h00, 0,0,1,0,0,  1, 8'hE5, 0,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 0,1,0,0,0,  0, 8'hA1, 1,0,0,0, 2,1});
    tbl.push_back('{0, 0, 8'h00, 1,0,0,0,0,  0, 8'hA1, 1,0,0,0, 2,1}); // clear in RUN ignored
    tbl.push_back('{0, 0, 8'h00, 0,0,1,0,0,  0, 8'hA1, 0,0,0,0, 2,1});
    tbl.push_back('{1, 4, 8'hF6, 1,0,0,0,0,  0, 8'hA1, 0,0,1,0, 4,1}); // clear+write
    tbl.push_back('{0, 0, 8'h00, 0,0,0,0,0,  0, 8'hA1, 0,0,0,0, 4,1});
    tbl.push_back('{0, 0, 8'h00, 0,1,0,0,0,  0, 8'h00, 1,0,0,0, 4,1}); // slot 0 was cleared
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  1, 8'h00, 1,0,0,0, 4,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  2, 8'h00, 1,0,0,0, 4,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  3, 8'h00, 1,0,0,0, 4,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  4, 8'hF6, 1,0,0,0, 4,1});
    tbl.push_back('{0, 0, 8'h00, 0,0,0,1,0,  4, 8'hF6, 0,1,0,0, 4,1});

    #2;
    chk_all("reset", 0, '0, 0, 0, 0, 0, 0, 0);
    #6 rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_idx = IDX_W'(tbl[i].widx); wr_data = mkword(tbl[i].wtag);
      clear = tbl[i].clr; start = tbl[i].sta; stop = tbl[i].stp;
      step = tbl[i].stv; loop_en = tbl[i].lp;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].eidx, mkword(tbl[i].etag), tbl[i].evalid,
              tbl[i].edone, tbl[i].eack, tbl[i].eerr, tbl[i].elast, tbl[i].eany);
    end
    idle_inputs();

    // Held step advances every cycle; a write past the bound extends the run.
    start = 1; tick(); start = 0;
    step = 1; tick(); chk_model("held_step1");
    wr_en = 1; wr_idx = 5'd6; wr_data = mkword(8'h66); tick(); chk_model("grow");
    wr_en = 0;
    for (int k = 0; k < 6; k++) begin tick(); chk_model($sformatf("held_step%0d", k + 2)); end
    step = 0;

    // Asynchronous reset in the middle of playback.
    start = 1; tick(); start = 0;
    step = 1; tick(); step = 0;
    chk_all("pre_rst", 1, '0, 1, 0, 0, 0, 6, 1);
    #2 rst_n = 1'b0;
    #1 chk_all("mid_rst", 0, '0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1 rst_n = 1'b1;
    start = 1; tick(); start = 0;
    chk_all("start_after_rst", 0, '0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 99) < 30);
      wr_idx  = IDX_W'($urandom_range(0, 14));
      wr_data = rnd_word();
      clear   = ($urandom_range(0, 99) < 3);
      start   = !clear && ($urandom_range(0, 99) < 10);
      stop    = ($urandom_range(0, 99) < 3);
      step    = ($urandom_range(0, 99) < 50);
      loop_en = ($urandom_range(0, 99) < 50);
      tick();
      chk_model($sformatf("rnd%0d", c));
      if ($urandom_range(0, 999) < 2) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_model($sformatf("rnd_rst%0d", c));
        #1 rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
